// File: rtl/axi_master_if.sv
// axi_master_if: single-outstanding AXI4 INCR burst master bridge.
// Optional error reporting: define AXI_MASTER_RESP_ERR_EN.
module axi_master_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = 8,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MST_ID         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]                req_len,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  input  logic [AXI_STRB_WIDTH-1:0] wr_strb,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      rd_last,
  output logic                      done_valid,
  output logic                      done_err,
  output logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  output logic [7:0]                aw_len,
  output logic [2:0]                aw_size,
  output logic [1:0]                aw_burst,
  output logic [AXI_ID_WIDTH-1:0]   aw_id,
  output logic [2:0]                aw_prot,
  output logic [3:0]                aw_region,
  output logic                      aw_lock,
  output logic [3:0]                aw_cache,
  output logic [3:0]                aw_qos,
  output logic [AXI_USER_WIDTH-1:0] aw_user,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  output logic [AXI_DATA_WIDTH-1:0] w_data,
  output logic [AXI_STRB_WIDTH-1:0] w_strb,
  output logic                      w_last,
  output logic [AXI_USER_WIDTH-1:0] w_user,
  output logic                      w_valid,
  input  logic                      w_ready,
  input  logic [1:0]                b_resp,
  input  logic [AXI_ID_WIDTH-1:0]   b_id,
  input  logic [AXI_USER_WIDTH-1:0] b_user,
  input  logic                      b_valid,
  output logic                      b_ready,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]                ar_len,
  output logic [2:0]                ar_size,
  output logic [1:0]                ar_burst,
  output logic [AXI_ID_WIDTH-1:0]   ar_id,
  output logic [2:0]                ar_prot,
  output logic [3:0]                ar_region,
  output logic                      ar_lock,
  output logic [3:0]                ar_cache,
  output logic [3:0]                ar_qos,
  output logic [AXI_USER_WIDTH-1:0] ar_user,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0] r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_last,
  input  logic [AXI_ID_WIDTH-1:0]   r_id,
  input  logic [AXI_USER_WIDTH-1:0] r_user,
  input  logic                      r_valid,
  output logic                      r_ready
);

  localparam int SIZE = $clog2(AXI_STRB_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW =
    AXI_ADDR_WIDTH'(AXI_STRB_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R
  } state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_cnt;
  logic                      last_beat;
  logic                      w_hs;
  logic                      r_hs;

  assign last_beat = (beat_cnt == len_q);
  assign w_hs = (state == S_W) && wr_valid && w_ready;
  assign r_hs = (state == S_R) && r_valid && rd_ready;

  assign req_ready = (state == S_IDLE) && !rst;

  assign aw_addr   = addr_q;
  assign aw_len    = len_q;
  assign aw_size   = 3'(SIZE);
  assign aw_burst  = 2'b01;
  assign aw_id     = AXI_ID_WIDTH'(MST_ID);
  assign aw_prot   = 3'd0;
  assign aw_region = 4'd0;
  assign aw_lock   = 1'b0;
  assign aw_cache  = 4'b0011;
  assign aw_qos    = 4'd0;
  assign aw_user   = '0;
  assign aw_valid  = (state == S_AW);

  assign ar_addr   = addr_q;
  assign ar_len    = len_q;
  assign ar_size   = 3'(SIZE);
  assign ar_burst  = 2'b01;
  assign ar_id     = AXI_ID_WIDTH'(MST_ID);
  assign ar_prot   = 3'd0;
  assign ar_region = 4'd0;
  assign ar_lock   = 1'b0;
  assign ar_cache  = 4'b0011;
  assign ar_qos    = 4'd0;
  assign ar_user   = '0;
  assign ar_valid  = (state == S_AR);

  assign w_data   = wr_data;
  assign w_strb   = wr_strb;
  assign w_user   = '0;
  assign w_last   = (state == S_W) && last_beat;
  assign w_valid  = (state == S_W) && wr_valid;
  assign wr_ready = (state == S_W) && w_ready;

  assign b_ready = (state == S_B);

  assign rd_data  = r_data;
  assign rd_valid = (state == S_R) && r_valid;
  assign rd_last  = (state == S_R) && last_beat;
  assign r_ready  = (state == S_R) && rd_ready;

  assign done_valid = ((state == S_B) && b_valid) ||
                      (r_hs && last_beat);

`ifdef AXI_MASTER_RESP_ERR_EN
  logic err_q;
  logic r_err;

  // r_last disagreeing with our own count is a protocol error
  assign r_err = r_resp[1] | (r_last != last_beat);

  assign done_err =
    ((state == S_B) && b_valid && b_resp[1]) ||
    (r_hs && last_beat && (err_q | r_err));

  // accumulate read-beat errors across the burst
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE) begin
      err_q <= 1'b0;
    end else if (r_hs) begin
      err_q <= err_q | r_err;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{b_resp[0], r_resp[0], b_id,
                        b_user, r_id, r_user};
`else
  assign done_err = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{b_resp, r_resp, r_last, b_id,
                        b_user, r_id, r_user};
`endif

  // transaction sequencing: request, address, data, response
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr & ~LOW;
            len_q    <= req_len;
            beat_cnt <= '0;
            state    <= req_write ? S_AW : S_AR;
          end
        end
        S_AW: begin
          if (aw_ready) state <= S_W;
        end
        S_W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= S_B;
          end
        end
        S_B: begin
          if (b_valid) state <= S_IDLE;
        end
        S_AR: begin
          if (ar_ready) state <= S_R;
        end
        S_R: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_if.sv
// tb_axi_master_if: randomized bench with a transaction-level
// model of one burst, checked against the DUT every cycle.
module tb_axi_master_if;

`ifdef AXI_MASTER_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [63:0] rd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic        done_valid, done_err;
  logic [63:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst;
  logic [3:0]  aw_id, ar_id, aw_region, ar_region;
  logic        aw_lock, ar_lock;
  logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos;
  logic [0:0]  aw_user, ar_user, w_user, b_user, r_user;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last, w_valid, w_ready;
  logic [1:0]  b_resp, r_resp;
  logic [3:0]  b_id, r_id;
  logic        b_valid, b_ready;
  logic [63:0] r_data;
  logic        r_last, r_valid, r_ready;

  axi_master_if dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last),
    .done_valid(done_valid), .done_err(done_err),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_id(aw_id), .aw_prot(aw_prot),
    .aw_region(aw_region), .aw_lock(aw_lock),
    .aw_cache(aw_cache), .aw_qos(aw_qos), .aw_user(aw_user),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .w_user(w_user), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_id(b_id), .b_user(b_user),
    .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_id(ar_id), .ar_prot(ar_prot),
    .ar_region(ar_region), .ar_lock(ar_lock),
    .ar_cache(ar_cache), .ar_qos(ar_qos), .ar_user(ar_user),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_id(r_id), .r_user(r_user), .r_valid(r_valid),
    .r_ready(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // per-burst payload and observations
  logic [63:0] data [256];
  logic [7:0]  strb [256];
  logic [63:0] cap_addr;
  logic [7:0]  cap_len;
  logic [2:0]  cap_size;
  logic [1:0]  cap_burst;
  int          nbeats, nlast, aw_vc;
  int          req_cyc, done_cyc;
  logic        last_err;

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = '0;
    req_len = '0; wr_data = '0; wr_strb = '0;
    wr_valid = 0; rd_ready = 0; aw_ready = 0;
    ar_ready = 0; w_ready = 0; b_valid = 0;
    b_resp = '0; b_id = '0; b_user = '0;
    r_valid = 0; r_data = '0; r_resp = '0;
    r_last = 0; r_id = '0; r_user = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_aw_valid"}, aw_valid, 0);
    chk({tag, "_ar_valid"}, ar_valid, 0);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_b_ready"}, b_ready, 0);
    chk({tag, "_r_ready"}, r_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_done"}, done_valid, 0);
  endtask

  // ph: 0 request, 1 address, 2 data, 3 write response
  task automatic run_txn(input bit wr,
                         input logic [63:0] addr,
                         input int len,
                         input int pct,
                         input int aw_hold,
                         input bit rd3,
                         input int err_beat,
                         input bit bad_last,
                         input int rst_at);
    int  ph, bi;
    bit  err, fin, exp_done, exp_err, hs, lastb;
    logic [63:0] ea;
    ph = 0; bi = 0; err = 0; fin = 0;
    nbeats = 0; nlast = 0; aw_vc = 0;
    req_cyc = -1; done_cyc = -1; last_err = 1'bx;
    ea = addr & ~64'h7;
    for (int i = 0; i <= len; i++) begin
      data[i] = {$urandom, $urandom};
      strb[i] = 8'($urandom);
    end
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(posedge clk); #1;
      if (rst_at >= 0 && ph == 2 && bi == rst_at) begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk_quiet("post_rst");
        return;
      end
      lastb = (bi == len);
      req_valid = (ph == 0);
      req_write = wr;
      req_addr  = addr;
      req_len   = 8'(len);
      aw_ready  = (aw_vc >= aw_hold) && rnd(pct);
      ar_ready  = rnd(pct);
      wr_valid  = rnd(pct);
      wr_data   = data[bi % 256];
      wr_strb   = strb[bi % 256];
      w_ready   = rnd(pct);
      b_valid   = (ph == 3) && rnd(pct);
      b_resp    = {err_beat >= 0, 1'($urandom)};
      b_id      = 4'($urandom);
      r_valid   = (ph == 2) && !wr && rnd(pct);
      r_data    = data[bi % 256];
      r_resp    = {bi == err_beat, 1'($urandom)};
      r_last    = lastb && !bad_last;
      r_id      = 4'($urandom);
      rd_ready  = rd3 ? (cyc % 3 != 0) : rnd(pct);
      @(negedge clk);
      exp_done = 0; exp_err = 0;
      if (ph == 3 && b_valid) begin
        exp_done = 1; exp_err = b_resp[1];
      end
      if (ph == 2 && !wr && r_valid && rd_ready && lastb) begin
        exp_done = 1;
        exp_err = err | r_resp[1] | (r_last != lastb);
      end
      exp_err = exp_err & ERR_EN;
      chk("req_ready", req_ready, ph == 0);
      chk("aw_valid", aw_valid, ph == 1 && wr);
      chk("ar_valid", ar_valid, ph == 1 && !wr);
      chk("w_valid", w_valid, ph == 2 && wr && wr_valid);
      chk("wr_ready", wr_ready, ph == 2 && wr && w_ready);
      chk("b_ready", b_ready, ph == 3);
      chk("rd_valid", rd_valid, ph == 2 && !wr && r_valid);
      chk("r_ready", r_ready, ph == 2 && !wr && rd_ready);
      chk("done_valid", done_valid, exp_done);
      chk("done_err", done_err, exp_err);
      if (ph == 1 && wr) begin
        aw_vc++;
        chk("aw_addr", aw_addr, ea);
        chk("aw_len", aw_len, 64'(len));
        chk("aw_cache", aw_cache, 3);
        cap_addr = aw_addr; cap_len = aw_len;
        cap_size = aw_size; cap_burst = aw_burst;
      end
      if (ph == 1 && !wr) begin
        chk("ar_addr", ar_addr, ea);
        chk("ar_len", ar_len, 64'(len));
        chk("ar_size", ar_size, 3);
        chk("ar_burst", ar_burst, 1);
        cap_addr = ar_addr; cap_len = ar_len;
        cap_size = ar_size; cap_burst = ar_burst;
      end
      if (ph == 2 && wr && wr_valid) begin
        chk("w_data", w_data, data[bi]);
        chk("w_strb", w_strb, strb[bi]);
        chk("w_last", w_last, lastb);
      end
      if (ph == 2 && !wr && r_valid) begin
        chk("rd_data", rd_data, data[bi]);
        chk("rd_last", rd_last, lastb);
      end
      if (exp_done) begin
        last_err = done_err;
        done_cyc = cyc;
        fin = 1;
      end
      unique case (ph)
        0: begin ph = 1; req_cyc = cyc; end
        1: if (wr ? aw_ready : ar_ready) ph = 2;
        2: begin
          hs = wr ? (wr_valid && w_ready)
                  : (r_valid && rd_ready);
          if (hs) begin
            nbeats++;
            if (wr ? w_last : rd_last) nlast++;
            if (!wr) err = err | r_resp[1] | (r_last != lastb);
            if (wr && lastb) ph = 3;
            bi++;
          end
        end
        default: ;
      endcase
    end
    if (!fin) chk("txn_timeout", 0, 1);
  endtask

  int d1;

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_aw_valid", aw_valid, 0);
    chk("reset_ar_valid", ar_valid, 0);
    chk("reset_done", done_valid, 0);
    chk("reset_done_err", done_err, 0);
    chk("reset_aw_addr", aw_addr, 0);
    chk("reset_aw_len", aw_len, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_quiet("idle");

    run_txn(1, 64'h1005, 3, 100, 0, 0, -1, 0, -1);
    chk("t1_aw_addr", cap_addr, 64'h1000);
    chk("t1_aw_len", cap_len, 3);
    chk("t1_aw_size", cap_size, 3);
    chk("t1_aw_burst", cap_burst, 1);
    chk("t1_beats", nbeats, 4);
    chk("t1_wlast_cnt", nlast, 1);
    chk("t1_latency", done_cyc - req_cyc, 6);
    chk("t1_err", last_err, 0);

    run_txn(0, 64'h2000, 7, 60, 0, 1, -1, 0, -1);
    chk("t2_beats", nbeats, 8);
    chk("t2_rdlast_cnt", nlast, 1);

    run_txn(0, 64'h3008, 3, 80, 0, 0, 1, 0, -1);
    chk("t3_err", last_err, ERR_EN);

    run_txn(0, 64'h3100, 2, 100, 0, 0, -1, 1, -1);
    chk("t3b_lastmis_err", last_err, ERR_EN);

    run_txn(1, 64'h4000, 1, 70, 0, 0, 0, 0, -1);
    chk("t3c_berr", last_err, ERR_EN);

    run_txn(1, 64'h5010, 1, 100, 10, 0, -1, 0, -1);
    chk("t4_aw_cycles", aw_vc, 11);
    chk("t4_beats", nbeats, 2);

    run_txn(1, 64'h6000, 3, 100, 0, 0, -1, 0, 2);
    run_txn(0, 64'h6020, 3, 100, 0, 0, -1, 0, -1);
    chk("t5_beats", nbeats, 4);
    chk("t5_err", last_err, 0);

    run_txn(1, 64'h7000, 2, 100, 0, 0, -1, 0, -1);
    d1 = done_cyc;
    run_txn(0, 64'h7000, 4, 100, 0, 0, -1, 0, -1);
    chk("t6_b2b_gap", req_cyc - d1, 1);
    chk("t6_beats", nbeats, 5);

    for (int k = 0; k < 20; k++) begin
      run_txn(1'($urandom),
              {32'h0, $urandom},
              $urandom_range(0, 15),
              $urandom_range(30, 100), 0, 0,
              rnd(30) ? 0 : -1, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
